spi_reg_bridge: RTL
===================

// Module: spi_reg_bridge
// PURPOSE
//  System-clock-domain stage directly downstream of the SPI peripheral (mode 0, MSB first, byte-wide).
//  Brings the peripheral's sck-domain DRDY, received byte and raw CSN into m_clk.
//  Decodes a framed command protocol and drives a simple register bus.
//  Supplies d_to_send back to the peripheral so register reads return data over MISO.
// PARAMETERS
//  BYTE_W       8      SPI byte width
//  ADDR_W       7      register address width; must equal BYTE_W-1 (cmd = {rw, addr})
//  SYNC_STAGES  2      flip-flop stages in each CDC synchronizer (>=2)
//  STATUS_BYTE  8'hA5  value presented on d_to_send when no read data is due
// PORTS
//  m_clk         in   1       system clock
//  rst           in   1       synchronous reset, active-high
//  csn_pad       in   1       raw SPI chip select, active-low, asynchronous to m_clk
//  drdy          in   1       byte-done pulse from SPI peripheral, sck domain
//  d_recieved    in   BYTE_W  received byte from peripheral, stable >=7 sck periods after drdy rises
//  d_to_send     out  BYTE_W  next byte for peripheral to shift out; loaded by peripheral at byte boundary
//  bus_addr      out  ADDR_W  register address
//  bus_wdata     out  BYTE_W  register write data
//  bus_we        out  1       write strobe, 1 m_clk cycle
//  bus_re        out  1       read strobe, 1 m_clk cycle
//  bus_rdata     in   BYTE_W  read data, valid exactly 1 cycle after bus_re
//  frame_active  out  1       high while a frame is being decoded
// BEHAVIOUR
//  Reset values: d_to_send=STATUS_BYTE; bus_addr, bus_wdata, bus_we, bus_re, frame_active = 0.
//  Reset values (internal): state=IDLE, ptr=0, armed=0, csn sync chain=0, drdy sync chain=0.
//  Clocking: m_clk must be >= 4x sck.
//  CDC: csn_pad and drdy each pass through SYNC_STAGES flops. byte_evt = rising edge of synced drdy.
//  CDC: d_recieved is captured on the byte_evt cycle; multi-bit bus is safe because it is held stable.
//  Frame arming: armed sets whenever synced csn=1. A frame may start only when armed=1.
//   -> reset mid-frame ignores the rest of that frame; decoding resumes after the next CS high->low.
//  FSM IDLE: d_to_send=STATUS_BYTE.
//   -> CMD on synced csn=0 && armed; armed clears, frame_active=1.
//  FSM CMD, on byte_evt: rw=byte[BYTE_W-1], ptr=byte[ADDR_W-1:0].
//   rw=0 -> WR.
//   rw=1 -> RD; same cycle: bus_re=1, bus_addr=ptr.
//   rw=1 -> next cycle: d_to_send<=bus_rdata, ptr<=ptr+1.
//  FSM RD, each byte_evt: bus_re at ptr; next cycle d_to_send<=bus_rdata, ptr+1. MOSI data ignored.
//   MISO sequence for read of A: STATUS, STATUS, reg[A], reg[A+1], ...
//   Prefetch issues bus_re one address beyond the last byte clocked out; register side must tolerate it.
//  FSM WR, each byte_evt: next cycle bus_we=1, bus_addr=ptr, bus_wdata=byte; then ptr+1.
//   WR keeps d_to_send=STATUS_BYTE.
//  Latency: byte_evt to bus strobe <= SYNC_STAGES+2 m_clk cycles.
//  Address wrap: ptr increments modulo 2^ADDR_W (7F -> 00).
//  Frame end: synced csn=1 in any state -> IDLE next cycle; frame_active=0; d_to_send=STATUS_BYTE.
//   No strobes issue after IDLE is entered.
//  Simultaneous byte_evt and csn rise: the byte is processed first (strobe issues), then IDLE.
//  Partial byte at CS rise: no byte_evt occurs and nothing is issued.
//  bus_we and bus_re are never high in the same cycle.
// STRUCTURE
//  Package spi_bridge_pkg: FSM state encoding (IDLE, CMD, RD, WR), CMD_RW_BIT, default STATUS_BYTE.
//  Sub-module cdc_sync_bit (parameter SYNC_STAGES, reset value 0): one instance each for csn_pad and drdy.
// TESTING
//  1 Write: frame 0x05,0x11,0x22 -> bus_we (addr 05, data 11) then (06, 22); bus_re never asserted.
//  2 Read: model reg[10]=AB, reg[11]=CD; MOSI 0x90,00,00,00 -> MISO A5,A5,AB,CD.
//  3 Wrap: write frame 0x7F,0x01,0x02 -> writes (7F,01) then (00,02).
//  4 Abort: CS high right after cmd 0x90 -> at most 1 bus_re; frame_active=0 within SYNC_STAGES+2 cycles.
//  5 Reset mid-frame with csn low: remaining bytes produce no strobes.
//  5 (cont.) CS high then low, then 0x03,0x44 -> bus_we (03, 44).
//  6 drdy rise coincident with CS rise in WR -> write still issued once; state IDLE afterwards.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - shared state encoding and protocol constants for the SPI register bridge
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    // Command byte is {rw, addr}; rw occupies the MSB of the byte
    localparam int CMD_RW_BIT = 7;

    localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - multi-flop single-bit synchronizer into the local clock domain
module cdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - decodes framed SPI commands into register bus reads/writes in m_clk
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int               BYTE_W      = 8,
    parameter int               ADDR_W      = 7,
    parameter int               SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
    input  logic              m_clk,
    input  logic              rst,
    input  logic              csn_pad,
    input  logic              drdy,
    input  logic [BYTE_W-1:0] d_recieved,
    output logic [BYTE_W-1:0] d_to_send,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BYTE_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [BYTE_W-1:0] bus_rdata,
    output logic              frame_active
);

    logic              csn_s;
    logic              drdy_s;
    logic              drdy_q;
    logic              byte_evt;
    state_t            state_q;
    state_t            state_next;
    logic              armed;
    logic [ADDR_W-1:0] ptr;
    logic              rd_pend;
    logic              issue_re;
    logic              issue_we;
    logic              load_ptr;
    logic              arm_clr;
    logic              rd_capture;
    logic [ADDR_W-1:0] cmd_addr;

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
        .clk (m_clk),
        .rst (rst),
        .d   (csn_pad),
        .q   (csn_s)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_drdy (
        .clk (m_clk),
        .rst (rst),
        .d   (drdy),
        .q   (drdy_s)
    );

    // d_recieved is held stable long after drdy, so it is sampled directly on byte_evt
    assign byte_evt   = drdy_s & ~drdy_q;
    assign cmd_addr   = d_recieved[ADDR_W-1:0];
    assign rd_capture = rd_pend && (state_q == RD);

    always_ff @(posedge m_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        issue_re   = 1'b0;
        issue_we   = 1'b0;
        load_ptr   = 1'b0;
        arm_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!csn_s && armed) begin
                    state_next = CMD;
                    arm_clr    = 1'b1;
                end
            end
            CMD: begin
                if (byte_evt) begin
                    load_ptr = 1'b1;
                    if (d_recieved[CMD_RW_BIT]) begin
                        state_next = RD;
                        issue_re   = 1'b1;
                    end else begin
                        state_next = WR;
                    end
                end
            end
            RD: begin
                if (byte_evt) begin
                    issue_re = 1'b1;
                end
            end
            WR: begin
                if (byte_evt) begin
                    issue_we = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A byte completing alongside CS rise is still issued above; the frame then closes
        if (csn_s && (state_q != IDLE)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge m_clk) begin
        if (rst) begin
            drdy_q    <= 1'b0;
            armed     <= 1'b0;
            ptr       <= '0;
            rd_pend   <= 1'b0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            d_to_send <= STATUS_BYTE;
        end else begin
            drdy_q  <= drdy_s;
            bus_we  <= issue_we;
            bus_re  <= issue_re;
            rd_pend <= bus_re;

            if (csn_s) begin
                armed <= 1'b1;
            end else if (arm_clr) begin
                armed <= 1'b0;
            end

            if (load_ptr) begin
                ptr <= cmd_addr;
            end else if (issue_we || rd_capture) begin
                ptr <= ptr + 1'b1;
            end

            if (issue_re) begin
                bus_addr <= load_ptr ? cmd_addr : ptr;
            end else if (issue_we) begin
                bus_addr  <= ptr;
                bus_wdata <= d_recieved;
            end

            if ((state_q == IDLE) || (state_next == IDLE)) begin
                d_to_send <= STATUS_BYTE;
            end else if (rd_capture) begin
                d_to_send <= bus_rdata;
            end
        end
    end

    assign frame_active = (state_q != IDLE);

endmodule
